max_pool_layer: RTL and testbench
=================================

Name: max_pool_layer

Overview:
- Downstream stage of conv_layer.
- Consumes conv_layer's output stream: one IEEE-754 double per cycle, tagged with channel/row/col indices.
- Performs non-overlapping POOL_DIM x POOL_DIM max pooling per channel; cells may arrive in any order.
- Emits each pooled result, with its output indices, once all of its cell's inputs have arrived.

Parameters:
- NUM_CHANNELS, 2, number of input feature maps (equals conv_layer NUM_OUTPUTS).
- IN_DIM, 3, input map width/height (conv_layer INPUT_DIM-KERNEL_DIM+1).
- POOL_DIM, 2, pooling window side and stride.
- DATA_SIZE, 64, data word width; IEEE-754 double bit pattern.
- IDX_W, 16, index field width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_SIZE  conv output value (double bits)
- in_index2  input  IDX_W  channel
- in_index1  input  IDX_W  row
- in_index0  input  IDX_W  col
- in_valid  input  1  input word present
- in_ready  output  1  stage can accept this cycle
- out_data  output  DATA_SIZE  pooled max (double bits)
- out_index2  output  IDX_W  channel
- out_index1  output  IDX_W  pooled row
- out_index0  output  IDX_W  pooled col
- out_valid  output  1  output word present
- out_ready  input  1  consumer accepts output
- dropped  output  1  sticky: an out-of-range input was discarded

Behaviour:
- OUT_DIM = IN_DIM / POOL_DIM (floor). NCELL = NUM_CHANNELS*OUT_DIM*OUT_DIM.
- Per cell state: max register (DATA_SIZE), count (clog2(POOL_DIM*POOL_DIM+1) bits).
- Reset (async, any time, including mid-window):
  - all counts 0; out_valid 0; out_data 0; out_index* 0; dropped 0.
  - in_ready is 1 after reset.
  - partial windows are lost.
- Accept = in_valid & in_ready. in_ready = !out_valid | out_ready (single output holding register).
- On accept, target cell = (ch, row/POOL_DIM, col/POOL_DIM).
- Out-of-range input: ch >= NUM_CHANNELS, row >= OUT_DIM*POOL_DIM, or col >= OUT_DIM*POOL_DIM.
  - Word is consumed; no state change; dropped set to 1 until reset.
  - Covers edge row/col 2 when IN_DIM=3, POOL_DIM=2.
- Compare rule:
  - Double bits treated as sign-magnitude.
  - Positive > negative; larger magnitude wins among positives; smaller magnitude wins among negatives.
  - +0 and -0 are equal.
  - On a tie, the stored value is kept.
  - NaN inputs are not supported (result undefined).
- count==0: max <= in_data. Otherwise max <= larger(max, in_data). count increments on every accepted in-range word.
- Duplicate indices are not detected; each one counts toward completion.
- Completion: when the incremented count equals POOL_DIM*POOL_DIM:
  - the cycle after accept, out_valid=1, out_data=final max, out_index2=ch, out_index1=row/POOL_DIM, out_index0=col/POOL_DIM;
  - cell count returns to 0 in the same update.
- Latency: 1 cycle from accept of the last window element to out_valid.
- Output holds stable while out_valid & !out_ready. Cleared the cycle after out_ready while no new completion occurs.
- Simultaneous cases:
  - out_ready and a completing accept in the same cycle: register reloads back-to-back, out_valid stays 1.
  - out_valid & !out_ready: in_ready=0, so no input is lost.
- At most one completion per cycle (one input per cycle).

Optional Feature:
- Macro: MAX_POOL_RELU_EN.
- Defined: each accepted in-range in_data with sign bit 1 is replaced by 64'h0 before compare/store (ReLU fused ahead of pooling). All outputs are >= +0.0, and -0.0 becomes +0.0.
- Undefined: raw values are pooled; negative maxima pass through unchanged.

Test Plan:
- Ch0 window (0,0),(0,1),(1,0),(1,1) = 1.0 (3FF0000000000000), 2.0 (4000000000000000), 0.5 (3FE0000000000000), -3.0 (C008000000000000), out_ready=1 -> one out_valid pulse, 1 cycle after 4th accept, out_data=4000000000000000, indices (0,0,0).
- All-negative window on ch1: -3.0, -1.0 (BFF0000000000000), -3.0, -3.0 -> out_data=BFF0000000000000 without macro; 0000000000000000 with MAX_POOL_RELU_EN.
- Interleaved ch0/ch1 elements in scrambled order -> exactly two outputs, each reporting the correct channel and its own max.
- Input at row 2 or col 2 (IN_DIM=3), and ch=2 -> no output; dropped=1 and stays 1; other windows are unaffected.
- out_ready=0 held 5 cycles after a completion -> out_data/out_index stable, in_ready=0; in_valid words are not consumed until out_ready=1.
- Assert rst after 2 of 4 window inputs, then feed a full window -> output reflects only post-reset data; all outputs were 0 during reset.

Source files
------------

// File: rtl/max_pool_layer.sv
// Non-overlapping POOL_DIM x POOL_DIM max pooling per channel over an indexed double stream; optional ReLU via MAX_POOL_RELU_EN.
// Latency: result registered 1 cycle after the accept of the last element of its window.
// Backpressure: single output holding register; in_ready = !out_valid | out_ready, so no input is lost while stalled.
module max_pool_layer #(
    parameter int NUM_CHANNELS = 2,
    parameter int IN_DIM       = 3,
    parameter int POOL_DIM     = 2,
    parameter int DATA_SIZE    = 64,
    parameter int IDX_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic [IDX_W-1:0]     in_index2,
    input  logic [IDX_W-1:0]     in_index1,
    input  logic [IDX_W-1:0]     in_index0,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [IDX_W-1:0]     out_index2,
    output logic [IDX_W-1:0]     out_index1,
    output logic [IDX_W-1:0]     out_index0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 dropped
);
    localparam int OUT_DIM = IN_DIM / POOL_DIM;
    localparam int NCELL   = NUM_CHANNELS * OUT_DIM * OUT_DIM;
    localparam int WIN     = POOL_DIM * POOL_DIM;
    localparam int CNT_W   = $clog2(WIN + 1);
    localparam int LIM     = OUT_DIM * POOL_DIM;

    logic [DATA_SIZE-1:0] max_q [NCELL];
    logic [DATA_SIZE-1:0] max_d [NCELL];
    logic [CNT_W-1:0]     cnt_q [NCELL];
    logic [CNT_W-1:0]     cnt_d [NCELL];

    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]     out_index2_q, out_index2_d;
    logic [IDX_W-1:0]     out_index1_q, out_index1_d;
    logic [IDX_W-1:0]     out_index0_q, out_index0_d;
    logic                 out_valid_q, out_valid_d;
    logic                 dropped_q, dropped_d;

    logic                 accept, in_range, complete;
    int                   cell_idx;
    logic [DATA_SIZE-1:0] val, sel_max, new_max;
    logic [CNT_W-1:0]     sel_cnt, new_cnt;

    // Sign-magnitude ordering: true only when cand is strictly greater, so ties keep the stored value.
    function automatic logic new_wins(input logic [DATA_SIZE-1:0] stored,
                                      input logic [DATA_SIZE-1:0] cand);
        logic s_neg, c_neg;
        logic [DATA_SIZE-2:0] s_mag, c_mag;
        s_neg = stored[DATA_SIZE-1];
        c_neg = cand[DATA_SIZE-1];
        s_mag = stored[DATA_SIZE-2:0];
        c_mag = cand[DATA_SIZE-2:0];
        if (s_mag == '0 && c_mag == '0) return 1'b0;
        if (s_neg != c_neg)             return s_neg;
        if (!s_neg)                     return c_mag > s_mag;
        return c_mag < s_mag;
    endfunction

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index2 = out_index2_q;
    assign out_index1 = out_index1_q;
    assign out_index0 = out_index0_q;
    assign dropped    = dropped_q;

    always_comb begin
        accept   = in_valid && in_ready;
        in_range = (int'(in_index2) < NUM_CHANNELS) && (int'(in_index1) < LIM) &&
                   (int'(in_index0) < LIM);
        cell_idx = int'(in_index2) * OUT_DIM * OUT_DIM +
                   (int'(in_index1) / POOL_DIM) * OUT_DIM + int'(in_index0) / POOL_DIM;

        val = in_data;
`ifdef MAX_POOL_RELU_EN
        if (in_data[DATA_SIZE-1]) val = '0;
`endif

        sel_max = '0;
        sel_cnt = '0;
        for (int c = 0; c < NCELL; c++) begin
            if (c == cell_idx) begin
                sel_max = max_q[c];
                sel_cnt = cnt_q[c];
            end
        end

        new_cnt  = sel_cnt + CNT_W'(1);
        new_max  = (sel_cnt == '0 || new_wins(sel_max, val)) ? val : sel_max;
        complete = accept && in_range && (new_cnt == CNT_W'(WIN));

        for (int c = 0; c < NCELL; c++) begin
            max_d[c] = max_q[c];
            cnt_d[c] = cnt_q[c];
            if (accept && in_range && c == cell_idx) begin
                max_d[c] = new_max;
                cnt_d[c] = complete ? '0 : new_cnt;
            end
        end

        dropped_d = dropped_q || (accept && !in_range);

        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_index2_d = out_index2_q;
        out_index1_d = out_index1_q;
        out_index0_d = out_index0_q;
        if (complete) begin
            out_valid_d  = 1'b1;
            out_data_d   = new_max;
            out_index2_d = in_index2;
            out_index1_d = in_index1 / IDX_W'(POOL_DIM);
            out_index0_d = in_index0 / IDX_W'(POOL_DIM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCELL; c++) begin
                max_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index2_q <= '0;
            out_index1_q <= '0;
            out_index0_q <= '0;
            dropped_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NCELL; c++) begin
                max_q[c] <= max_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index2_q <= out_index2_d;
            out_index1_q <= out_index1_d;
            out_index0_q <= out_index0_d;
            dropped_q    <= dropped_d;
        end
    end
endmodule

// File: tb/tb_max_pool_layer.sv
// Bench for max_pool_layer: real-valued reference model checked every cycle, plus literal expectations per scenario.
module tb_max_pool_layer;
    localparam int NC = 2, IND = 3, P = 2, DW = 64, IW = 16;
    localparam int OD = IND / P;
    localparam int NCL = NC * OD * OD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_index2 = '0, in_index1 = '0, in_index0 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index2, out_index1, out_index0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          dropped;

    always #5 clk = ~clk;

    max_pool_layer #(.NUM_CHANNELS(NC), .IN_DIM(IND), .POOL_DIM(P), .DATA_SIZE(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_index2(in_index2), .in_index1(in_index1), .in_index0(in_index0),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_index2(out_index2), .out_index1(out_index1), .out_index0(out_index0),
        .out_valid(out_valid), .out_ready(out_ready), .dropped(dropped)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: window maxima chosen by real-number comparison.
    logic [63:0] m_max [NCL];
    int          m_cnt [NCL];
    logic        m_vld = 1'b0, m_drop = 1'b0;
    logic [63:0] m_data = '0;
    logic [IW-1:0] m_i2 = '0, m_i1 = '0, m_i0 = '0;

    function automatic logic [63:0] prep(input logic [63:0] v);
`ifdef MAX_POOL_RELU_EN
        return v[63] ? 64'h0 : v;
`else
        return v;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        bit rdy, done;
        int c;
        logic [63:0] v;
        if (rst) begin
            for (int k = 0; k < NCL; k++) m_cnt[k] = 0;
            m_vld = 1'b0; m_drop = 1'b0; m_data = '0;
            m_i2 = '0; m_i1 = '0; m_i0 = '0;
        end else begin
            rdy  = !m_vld || out_ready;
            done = 1'b0;
            if (in_valid && rdy) begin
                if (in_index2 >= NC || in_index1 >= OD * P || in_index0 >= OD * P) begin
                    m_drop = 1'b1;
                end else begin
                    c = in_index2 * OD * OD + (in_index1 / P) * OD + in_index0 / P;
                    v = prep(in_data);
                    if (m_cnt[c] == 0 || $bitstoreal(v) > $bitstoreal(m_max[c])) m_max[c] = v;
                    m_cnt[c]++;
                    if (m_cnt[c] == P * P) begin
                        m_cnt[c] = 0;
                        done   = 1'b1;
                        m_data = m_max[c];
                        m_i2   = in_index2;
                        m_i1   = in_index1 / P;
                        m_i0   = in_index0 / P;
                    end
                end
            end
            if (done) m_vld = 1'b1;
            else if (out_ready) m_vld = 1'b0;
        end
    end

    logic [63:0] got_d [$];
    logic [47:0] got_i [$];

    always @(negedge clk) begin
        if (rst || in_valid || m_vld || out_valid) begin
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            chk("in_ready", 64'(in_ready), 64'(!m_vld || out_ready));
            chk("dropped", 64'(dropped), 64'(m_drop));
            if (m_vld || rst) begin
                chk("out_data", out_data, m_data);
                chk("out_index", 64'({out_index2, out_index1, out_index0}), 64'({m_i2, m_i1, m_i0}));
            end
        end
        if (out_valid && out_ready && !rst) begin
            got_d.push_back(out_data);
            got_i.push_back({out_index2, out_index1, out_index0});
        end
    end

    function automatic logic [63:0] gd(input int k);
        return (k < got_d.size()) ? got_d[k] : 64'hx;
    endfunction
    function automatic logic [63:0] gi(input int k);
        return (k < got_i.size()) ? 64'(got_i[k]) : 64'hx;
    endfunction
    function automatic logic [63:0] idx3(input int a, input int b, input int c);
        logic [47:0] t;
        t = {16'(a), 16'(b), 16'(c)};
        return 64'(t);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input int ch, input int row, input int col, input logic [63:0] d);
        bit acc;
        acc = 1'b0;
        in_index2 = 16'(ch); in_index1 = 16'(row); in_index0 = 16'(col);
        in_data = d; in_valid = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #2 rst = 1'b0;
        idle(1);

        // Mixed-sign window on ch0: max 2.0, one pulse one cycle after the last accept.
        send(0, 0, 0, 64'h3FF0000000000000);
        send(0, 0, 1, 64'h4000000000000000);
        send(0, 1, 0, 64'h3FE0000000000000);
        send(0, 1, 1, 64'hC008000000000000);
        @(negedge clk);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("t1_pulse_end", 64'(out_valid), 64'd0);
        idle(1);
        chk("t1_count", 64'(got_d.size()), 64'd1);
        chk("t1_data", gd(0), 64'h4000000000000000);
        chk("t1_idx", gi(0), idx3(0, 0, 0));
        got_d.delete(); got_i.delete();

        // All-negative window on ch1.
        send(1, 0, 0, 64'hC008000000000000);
        send(1, 0, 1, 64'hBFF0000000000000);
        send(1, 1, 0, 64'hC008000000000000);
        send(1, 1, 1, 64'hC008000000000000);
        idle(3);
        chk("t2_count", 64'(got_d.size()), 64'd1);
`ifdef MAX_POOL_RELU_EN
        chk("t2_data", gd(0), 64'h0000000000000000);
`else
        chk("t2_data", gd(0), 64'hBFF0000000000000);
`endif
        chk("t2_idx", gi(0), idx3(1, 0, 0));
        got_d.delete(); got_i.delete();

        // Interleaved channels in scrambled order.
        send(1, 1, 1, 64'h4014000000000000);
        send(0, 0, 1, 64'hC000000000000000);
        send(0, 1, 1, 64'h401C000000000000);
        send(1, 0, 0, 64'h3FF0000000000000);
        send(0, 0, 0, 64'h8000000000000000);
        send(1, 1, 0, 64'h4018000000000000);
        send(0, 1, 0, 64'h4008000000000000);
        send(1, 0, 1, 64'hBFF0000000000000);
        idle(3);
        chk("t3_count", 64'(got_d.size()), 64'd2);
        chk("t3_data0", gd(0), 64'h401C000000000000);
        chk("t3_idx0", gi(0), idx3(0, 0, 0));
        chk("t3_data1", gd(1), 64'h4018000000000000);
        chk("t3_idx1", gi(1), idx3(1, 0, 0));
        got_d.delete(); got_i.delete();

        // Out-of-range words dropped around a partial ch1 window.
        send(1, 0, 0, 64'h4000000000000000);
        send(0, 2, 0, 64'h4022000000000000);
        send(0, 0, 2, 64'h4022000000000000);
        send(2, 0, 0, 64'h4022000000000000);
        idle(2);
        chk("t4_no_out", 64'(got_d.size()), 64'd0);
        chk("t4_dropped", 64'(dropped), 64'd1);
        send(1, 0, 1, 64'h3FF0000000000000);
        send(1, 1, 0, 64'h3FF0000000000000);
        send(1, 1, 1, 64'h3FF0000000000000);
        idle(3);
        chk("t4_count", 64'(got_d.size()), 64'd1);
        chk("t4_data", gd(0), 64'h4000000000000000);
        chk("t4_idx", gi(0), idx3(1, 0, 0));
        chk("t4_dropped_sticky", 64'(dropped), 64'd1);
        got_d.delete(); got_i.delete();

        // Output stall: result held, next word waits.
        out_ready = 1'b0;
        send(0, 0, 0, 64'h3FD0000000000000);
        send(0, 0, 1, 64'h3FE8000000000000);
        send(0, 1, 0, 64'h3FE0000000000000);
        send(0, 1, 1, 64'h3FD0000000000000);
        in_index2 = 16'd0; in_index1 = 16'd0; in_index0 = 16'd0;
        in_data = 64'h4020000000000000; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(out_valid), 64'd1);
            chk("t5_hold_data", out_data, 64'h3FE8000000000000);
            chk("t5_hold_idx", 64'({out_index2, out_index1, out_index0}), idx3(0, 0, 0));
            chk("t5_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #2 out_ready = 1'b1;
        send(0, 0, 0, 64'h4020000000000000);
        send(0, 0, 1, 64'h3FF0000000000000);
        send(0, 1, 0, 64'h3FF0000000000000);
        send(0, 1, 1, 64'h3FF0000000000000);
        idle(3);
        chk("t5_count", 64'(got_d.size()), 64'd2);
        chk("t5_data0", gd(0), 64'h3FE8000000000000);
        chk("t5_data1", gd(1), 64'h4020000000000000);
        got_d.delete(); got_i.delete();

        // Reset mid-window: partial data must be lost.
        send(0, 0, 0, 64'h4059000000000000);
        send(0, 0, 1, 64'h4049000000000000);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t6_rst_valid", 64'(out_valid), 64'd0);
            chk("t6_rst_data", out_data, 64'd0);
            chk("t6_rst_dropped", 64'(dropped), 64'd0);
            chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #2 rst = 1'b0;
        idle(1);
        send(0, 1, 0, 64'h3FF8000000000000);
        send(0, 1, 1, 64'h3FE0000000000000);
        idle(2);
        chk("t6_no_early_out", 64'(got_d.size()), 64'd0);
        send(0, 0, 0, 64'h3FD0000000000000);
        send(0, 0, 1, 64'hBFF0000000000000);
        idle(3);
        chk("t6_count", 64'(got_d.size()), 64'd1);
        chk("t6_data", gd(0), 64'h3FF8000000000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
